// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared definitions for the UART receive frame parser.
//   HDR_BYTE0/HDR_BYTE1 : frame header bytes (0x55, 0xAA)
//   ERR_*               : values reported on o_err_code
//   state_e             : parser FSM states
package uart_rx_frame_parser_pkg;

  localparam logic [7:0] HDR_BYTE0 = 8'h55;
  localparam logic [7:0] HDR_BYTE1 = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/uart_rx_frame_parser_buf.sv
// Payload buffer for the frame parser: one write port, one registered read port.
//   i_clk, i_rst         : clock, asynchronous active-low reset (read register only)
//   i_wr_en/addr/data    : write one payload byte
//   i_rd_en, i_rd_addr   : load the read register from i_rd_addr
//   o_rd_data            : registered read data, holds while i_rd_en is low
module uart_frame_buf #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DEPTH      = 16,
  parameter int P_AW         = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic [P_AW-1:0]         i_wr_addr,
  input  logic [P_DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rd_en,
  input  logic [P_AW-1:0]         i_rd_addr,
  output logic [P_DATA_WIDTH-1:0] o_rd_data
);

  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_data_q <= '0;
    end else if (i_rd_en) begin
      rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Extracts 0x55 0xAA LEN payload CHK frames from the UART receive byte stream.
// Payload is buffered and released over valid/ready only after the checksum
// (8-bit sum of LEN and payload) matches; bad frames are dropped and reported.
//   i_clk, i_rst              : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid     : received byte, one-cycle valid pulse
//   o_pkt_data/valid/last     : payload stream out, i_pkt_ready accepts
//   o_err_valid, o_err_code   : discard pulse, code held until next error
//   o_drop_pulse              : byte received while draining was discarded
module uart_rx_frame_parser
  import uart_rx_frame_parser_pkg::*;
#(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_MAX_LEN        = 16,
  parameter int P_TIMEOUT_CYCLES = 10000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_pkt_data,
  output logic                    o_pkt_valid,
  input  logic                    i_pkt_ready,
  output logic                    o_pkt_last,
  output logic                    o_err_valid,
  output logic [1:0]              o_err_code,
  output logic                    o_drop_pulse
);

  localparam int AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam int LW = $clog2(P_MAX_LEN + 1);
  localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);

  state_e                  state_q;
  logic [LW-1:0]           len_q;
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [P_DATA_WIDTH-1:0] sum_q;
  logic [TW-1:0]           tmo_q;
  logic                    pkt_valid_q;
  logic                    pkt_last_q;
  logic                    err_valid_q;
  logic [1:0]              err_code_q;
  logic                    drop_q;

  logic                    handshake;
  logic                    tmo_run;
  logic                    tmo_expire;
  logic                    len_ok;
  logic                    chk_ok;
  logic                    wr_en;
  logic                    wr_last;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic                    rd_next_last;

  assign handshake  = pkt_valid_q & i_pkt_ready;
  assign tmo_run    = (state_q == ST_HDR2) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // A byte in the expiry cycle keeps the frame alive.
  assign tmo_expire = tmo_run && !i_rx_valid &&
                      (tmo_q == TW'(P_TIMEOUT_CYCLES - 1));
  assign len_ok     = (i_rx_data != '0) &&
                      (i_rx_data <= P_DATA_WIDTH'(P_MAX_LEN));
  assign chk_ok     = (i_rx_data == sum_q);
  assign wr_en      = (state_q == ST_PAYLOAD) && i_rx_valid;
  assign wr_last    = (LW'(wr_ptr_q) == (len_q - LW'(1)));
  // True when the byte after the one now presented is the final one.
  assign rd_next_last = ((LW'(rd_ptr_q) + LW'(2)) == len_q);

  // The buffer read is registered, so the address for the next presented
  // byte is issued in the cycle that accepts the current one (or the CHK
  // cycle for byte 0). This gives first valid one cycle after CHK and
  // one byte per cycle while ready stays high.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_ptr_q;
    if (state_q == ST_CHK && i_rx_valid && chk_ok) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state_q == ST_DRAIN && handshake && !pkt_last_q) begin
      rd_en   = 1'b1;
      rd_addr = rd_ptr_q + 1'b1;
    end
  end

  uart_frame_buf #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_DEPTH      (P_MAX_LEN),
    .P_AW         (AW)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_rx_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (o_pkt_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      drop_q      <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      tmo_q       <= (tmo_run && !i_rx_valid && !tmo_expire) ? tmo_q + 1'b1 : '0;

      if (tmo_expire) begin
        state_q     <= ST_IDLE;
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_rx_valid && i_rx_data == HDR_BYTE0) begin
              state_q <= ST_HDR2;
            end
          end
          ST_HDR2: begin
            if (i_rx_valid) begin
              if (i_rx_data == HDR_BYTE1) begin
                state_q <= ST_LEN;
              end else if (i_rx_data != HDR_BYTE0) begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_LEN: begin
            if (i_rx_valid) begin
              if (len_ok) begin
                len_q    <= LW'(i_rx_data);
                sum_q    <= i_rx_data;
                wr_ptr_q <= '0;
                state_q  <= ST_PAYLOAD;
              end else begin
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_BAD_LEN;
                state_q     <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: begin
            if (i_rx_valid) begin
              sum_q    <= sum_q + i_rx_data;
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (wr_last) begin
                state_q <= ST_CHK;
              end
            end
          end
          ST_CHK: begin
            if (i_rx_valid) begin
              if (chk_ok) begin
                rd_ptr_q    <= '0;
                pkt_valid_q <= 1'b1;
                pkt_last_q  <= (len_q == LW'(1));
                state_q     <= ST_DRAIN;
              end else begin
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_CHKSUM;
                state_q     <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (i_rx_valid) begin
              drop_q <= 1'b1;
            end
            if (handshake) begin
              if (pkt_last_q) begin
                pkt_valid_q <= 1'b0;
                pkt_last_q  <= 1'b0;
                state_q     <= ST_IDLE;
              end else begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                pkt_last_q <= rd_next_last;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pkt_valid  = pkt_valid_q;
  assign o_pkt_last   = pkt_last_q;
  assign o_err_valid  = err_valid_q;
  assign o_err_code   = err_code_q;
  assign o_drop_pulse = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser.
module tb_uart_rx_frame_parser;

  localparam int MAXL = 16;
  localparam int TMO  = 64;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] rx_data   = '0;
  logic       rx_valid  = 1'b0;
  logic       pkt_ready = 1'b1;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       err_valid;
  logic [1:0] err_code;
  logic       drop_pulse;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];   // {last, data} of every accepted byte
  logic [8:0] exp_q[$];
  int         errs_q[$];  // error codes in order of their pulses
  int         drops      = 0;
  int         stall_viol = 0;
  logic       prev_hold  = 1'b0;
  logic [8:0] prev_word  = '0;

  logic [7:0] pl[MAXL];
  int         plen;
  int         rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low

  uart_rx_frame_parser #(
    .P_DATA_WIDTH     (8),
    .P_MAX_LEN        (MAXL),
    .P_TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_pkt_data   (pkt_data),
    .o_pkt_valid  (pkt_valid),
    .i_pkt_ready  (pkt_ready),
    .o_pkt_last   (pkt_last),
    .o_err_valid  (err_valid),
    .o_err_code   (err_code),
    .o_drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !(pkt_valid && {pkt_last, pkt_data} == prev_word)) stall_viol++;
      if (pkt_valid && pkt_ready) got_q.push_back({pkt_last, pkt_data});
      if (err_valid) errs_q.push_back(int'(err_code));
      if (drop_pulse) drops++;
      prev_hold = pkt_valid && !pkt_ready;
      prev_word = {pkt_last, pkt_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = ~pkt_ready;
        2:       pkt_ready = 1'($urandom % 2);
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] model_chk();
    int s = plen;
    for (int i = 0; i < plen; i++) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic model_push();
    for (int i = 0; i < plen; i++) exp_q.push_back({(i == plen - 1), pl[i]});
  endtask

  task automatic rand_payload(input int len);
    plen = len;
    for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom);
  endtask

  task automatic send_frame(input int gap, input logic [7:0] chk_flip);
    send_byte(8'h55); idle(gap);
    send_byte(8'hAA); idle(gap);
    send_byte(8'(plen));
    for (int i = 0; i < plen; i++) begin
      idle(gap);
      send_byte(pl[i]);
    end
    idle(gap);
    send_byte(model_chk() ^ chk_flip);
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int c = 0;
    while (got_q.size() < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset();
    idle(3);
    @(negedge clk);
    checks++;
    if ({pkt_valid, pkt_last, err_valid, drop_pulse, err_code, pkt_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {pkt_valid, pkt_last, err_valid, drop_pulse, err_code, pkt_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    logic [10:0] want[4];
    int base, ebase;
    want[0] = {1'b1, 1'b0, 8'h11};
    want[1] = {1'b1, 1'b0, 8'h22};
    want[2] = {1'b1, 1'b1, 8'h33};
    want[3] = {1'b0, 1'b0, 8'h00};
    rdy_mode = 0;
    idle(2);
    ebase = errs_q.size();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({pkt_valid, pkt_last, (pkt_valid ? pkt_data : 8'h00)} !== want[i]) begin
        errors++;
        $display("FAIL vector_stream[%0d]: got valid/last/data %b/%b/%h required %h",
                 i, pkt_valid, pkt_last, pkt_data, want[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (errs_q.size() != ebase) begin
      errors++;
      $display("FAIL vector_no_err: got %0d errors required 0", errs_q.size() - ebase);
    end
    // Random frames, including both length limits.
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      rand_payload(f == 0 ? 1 : (f == 1 ? MAXL : int'($urandom_range(1, MAXL))));
      base = got_q.size();
      exp_q.delete();
      model_push();
      send_frame(0, 8'h00);
      wait_pkts(base + plen, 200);
      idle(2);
      checks++;
      if (got_q.size() - base != exp_q.size()) begin
        errors++;
        $display("FAIL rand_frame_len[%0d]: got %0d bytes required %0d", f, got_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_frame_byte[%0d][%0d]: got %h required %h", f, i, got_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (errs_q.size() != ebase) begin
      errors++;
      $display("FAIL rand_frame_no_err: got %0d errors required 0", errs_q.size() - ebase);
    end
    rdy_mode = 0;
  endtask

  task automatic test_bad_checksum();
    int base, ebase;
    logic [7:0] flip;
    base = got_q.size();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    @(negedge clk);
    checks++;
    if ({err_valid, err_code} !== 3'b1_10) begin
      errors++;
      $display("FAIL chk_err_pulse: got valid/code %b/%0d required 1/2", err_valid, err_code);
    end
    @(negedge clk);
    checks++;
    if ({err_valid, err_code} !== 3'b0_10) begin
      errors++;
      $display("FAIL chk_err_hold: got valid/code %b/%0d required 0/2", err_valid, err_code);
    end
    @(posedge clk); #1;
    for (int f = 0; f < 4; f++) begin
      rand_payload(int'($urandom_range(1, MAXL)));
      flip  = 8'($urandom_range(1, 255));
      ebase = errs_q.size();
      send_frame(0, flip);
      idle(3);
      checks++;
      if (errs_q.size() != ebase + 1 || errs_q[errs_q.size() - 1] != 2) begin
        errors++;
        $display("FAIL rand_chk_err[%0d]: got %0d new errors required one code 2", f, errs_q.size() - ebase);
      end
    end
    idle(5);
    checks++;
    if (got_q.size() != base) begin
      errors++;
      $display("FAIL chk_no_pkt: got %0d bytes required 0", got_q.size() - base);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] bad[3];
    int base, ebase;
    bad[0] = 8'h00; bad[1] = 8'h11; bad[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h55); send_byte(8'hAA); send_byte(bad[k]);
      @(negedge clk);
      checks++;
      if ({err_valid, err_code} !== 3'b1_01) begin
        errors++;
        $display("FAIL len_err[%0d]: got valid/code %b/%0d required 1/1", k, err_valid, err_code);
      end
      @(posedge clk); #1;
    end
    // Broken header then a repeated 0x55 before a real frame.
    ebase = errs_q.size();
    base  = got_q.size();
    send_byte(8'h55); send_byte(8'h13); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h55);
    rand_payload(int'($urandom_range(1, MAXL)));
    exp_q.delete();
    model_push();
    send_frame(0, 8'h00);
    wait_pkts(base + plen, 100);
    idle(2);
    checks++;
    if (got_q.size() - base != exp_q.size() || errs_q.size() != ebase) begin
      errors++;
      $display("FAIL resync_count: got %0d bytes %0d errors required %0d bytes 0 errors",
               got_q.size() - base, errs_q.size() - ebase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL resync_byte[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int base, ebase;
    ebase = errs_q.size();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    idle(TMO - 2);
    checks++;
    if (errs_q.size() != ebase) begin
      errors++;
      $display("FAIL timeout_early: got %0d errors required 0", errs_q.size() - ebase);
    end
    idle(10);
    checks++;
    if (errs_q.size() != ebase + 1 || errs_q[errs_q.size() - 1] != 3) begin
      errors++;
      $display("FAIL timeout_payload: got %0d new errors required one code 3", errs_q.size() - ebase);
    end
    ebase = errs_q.size();
    send_byte(8'h55);
    idle(TMO + 5);
    checks++;
    if (errs_q.size() != ebase + 1 || errs_q[errs_q.size() - 1] != 3) begin
      errors++;
      $display("FAIL timeout_hdr2: got %0d new errors required one code 3", errs_q.size() - ebase);
    end
    // TMO-1 idle cycles between bytes must not abort the frame.
    for (int g = 0; g < 2; g++) begin
      ebase = errs_q.size();
      base  = got_q.size();
      rand_payload(g == 0 ? 3 : 2);
      exp_q.delete();
      model_push();
      send_frame(g == 0 ? 0 : TMO - 1, 8'h00);
      wait_pkts(base + plen, 100);
      idle(2);
      checks++;
      if (got_q.size() - base != exp_q.size() || errs_q.size() != ebase) begin
        errors++;
        $display("FAIL timeout_after[%0d]: got %0d bytes %0d errors required %0d bytes 0 errors",
                 g, got_q.size() - base, errs_q.size() - ebase, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL timeout_after_byte[%0d][%0d]: got %h required %h", g, i, got_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_drain_stall();
    int base, ebase, dbase, sbase;
    rdy_mode = 3;
    idle(2);
    base  = got_q.size();
    ebase = errs_q.size();
    dbase = drops;
    sbase = stall_viol;
    rand_payload(4);
    exp_q.delete();
    model_push();
    send_frame(0, 8'h00);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    idle(3);
    checks++;
    if (drops - dbase != 3) begin
      errors++;
      $display("FAIL drain_drops: got %0d drop pulses required 3", drops - dbase);
    end
    @(negedge clk);
    checks++;
    if ({pkt_valid, pkt_last, pkt_data} !== {2'b10, pl[0]}) begin
      errors++;
      $display("FAIL drain_hold: got valid/last/data %b/%b/%h required 1/0/%h", pkt_valid, pkt_last, pkt_data, pl[0]);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_pkts(base + 4, 100);
    idle(3);
    rdy_mode = 0;
    checks++;
    if (got_q.size() - base != 4 || stall_viol != sbase || errs_q.size() != ebase) begin
      errors++;
      $display("FAIL drain_summary: got %0d bytes %0d stall faults %0d errors required 4 0 0",
               got_q.size() - base, stall_viol - sbase, errs_q.size() - ebase);
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL drain_byte[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    rdy_mode = 0;
    idle(2);
    base = got_q.size();
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      rand_payload(int'($urandom_range(1, MAXL)));
      model_push();
      send_frame(0, 8'h00);
      idle(plen + 2);
    end
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, ebase;
    base  = got_q.size();
    ebase = errs_q.size();
    rdy_mode = 0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
    send_byte(8'h10); send_byte(8'h20);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_valid, pkt_last, err_valid, drop_pulse, err_code} !== 6'd0) begin
      errors++;
      $display("FAIL rst_payload: got %b required 0", {pkt_valid, pkt_last, err_valid, drop_pulse, err_code});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'h30); send_byte(8'h40); send_byte(8'hA4);
    idle(5);
    // Drain interrupted by reset while the consumer stalls.
    rdy_mode = 3;
    idle(2);
    rand_payload(5);
    send_frame(0, 8'h00);
    idle(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_valid, pkt_last, err_valid, drop_pulse, err_code, pkt_data} !== 14'd0) begin
      errors++;
      $display("FAIL rst_drain: got %h required 0",
               {pkt_valid, pkt_last, err_valid, drop_pulse, err_code, pkt_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(10);
    checks++;
    if (got_q.size() != base || errs_q.size() != ebase) begin
      errors++;
      $display("FAIL rst_no_partial: got %0d bytes %0d errors required 0 0",
               got_q.size() - base, errs_q.size() - ebase);
    end
    rand_payload(int'($urandom_range(1, MAXL)));
    exp_q.delete();
    model_push();
    send_frame(0, 8'h00);
    wait_pkts(base + plen, 100);
    idle(2);
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL rst_recover_count: got %0d bytes required %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_recover_byte[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_len();
    test_timeout();
    test_drain_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
